// File: rtl/div_issue_ctrl_if.sv
// Bundle of every handshake/bus signal around div_issue_ctrl.
//   in_*  : request port (valid/ready), driven by the requester
//   div_* : start pulse + operands to the divider, quotient/remainder/done back
//   out_* : tagged result port (valid/ready) towards the consumer
// slave  = view of div_issue_ctrl itself, master = view of its surroundings.
interface div_issue_ctrl_if #(
  parameter int PARALLELISM = 32,
  parameter int TAG_W       = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_usigned;
  logic [PARALLELISM-1:0] in_dividend;
  logic [PARALLELISM-1:0] in_divisor;
  logic [TAG_W-1:0]       in_tag;

  logic                   div_valid;
  logic                   div_usigned;
  logic [PARALLELISM-1:0] div_dividend;
  logic [PARALLELISM-1:0] div_divisor;
  logic [PARALLELISM-1:0] div_quotient;
  logic [PARALLELISM-1:0] div_reminder;
  logic                   div_res_ready;

  logic                   out_valid;
  logic                   out_ready;
  logic [PARALLELISM-1:0] out_quotient;
  logic [PARALLELISM-1:0] out_reminder;
  logic [TAG_W-1:0]       out_tag;
  logic                   out_div_by_zero;
  logic                   out_timeout;

  modport slave (
    input  in_valid, in_usigned, in_dividend, in_divisor, in_tag,
    input  div_quotient, div_reminder, div_res_ready,
    input  out_ready,
    output in_ready,
    output div_valid, div_usigned, div_dividend, div_divisor,
    output out_valid, out_quotient, out_reminder, out_tag, out_div_by_zero, out_timeout
  );

  modport master (
    output in_valid, in_usigned, in_dividend, in_divisor, in_tag,
    output div_quotient, div_reminder, div_res_ready,
    output out_ready,
    input  in_ready,
    input  div_valid, div_usigned, div_dividend, div_divisor,
    input  out_valid, out_quotient, out_reminder, out_tag, out_div_by_zero, out_timeout
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Request front-end for the divider. Requests are queued in a DEPTH-entry
// FIFO and issued one at a time: the head is popped, a one-cycle div_valid
// start pulse is sent, and the result is captured on the rising edge of
// div_res_ready. Zero divisors are answered locally (q = all ones,
// r = dividend) and a watchdog aborts operations that never finish.
// Ports:
//   clk   : clock
//   rst_n : asynchronous reset, active HIGH despite the name
//   bus   : div_issue_ctrl_if.slave (request, divider and result ports)
module div_issue_ctrl #(
  parameter int PARALLELISM = 32,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT     = 128
) (
  input logic            clk,
  input logic            rst_n,
  div_issue_ctrl_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int WD_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic                   usigned;
    logic [PARALLELISM-1:0] dividend;
    logic [PARALLELISM-1:0] divisor;
    logic [TAG_W-1:0]       tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t                 state_q, state_d;
  req_t                   mem [DEPTH];
  req_t                   req_in, head;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   push, pop, head_zero;
  logic                   res_edge, wd_hit;
  logic [WD_W-1:0]        wd_q;
  logic                   rr_prev_q;
  logic                   dus_q, dbz_q, to_q;
  logic [PARALLELISM-1:0] ddd_q, ddv_q, q_q, r_q;
  logic [TAG_W-1:0]       tag_q;

  assign req_in    = '{bus.in_usigned, bus.in_dividend, bus.in_divisor, bus.in_tag};
  assign head      = mem[rd_ptr];
  assign head_zero = (head.divisor == '0);

  // Ready depends only on the stored count, so a pop never opens a full FIFO
  // in the same cycle; held low while reset is asserted.
  assign bus.in_ready = !rst_n && (count != (AW+1)'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == IDLE) && (count != '0);

  // Edges only matter in WAIT, so a late done after an abort is harmless.
  assign res_edge = bus.div_res_ready && !rr_prev_q;
  assign wd_hit   = (wd_q == WD_W'(TIMEOUT-1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop) state_d = head_zero ? HOLD : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (res_edge || wd_hit) state_d = HOLD;
      HOLD:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rr_prev_q <= 1'b0;
      wd_q      <= '0;
      dus_q     <= 1'b0;
      ddd_q     <= '0;
      ddv_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      tag_q     <= '0;
      dbz_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      rr_prev_q <= bus.div_res_ready;
      case (state_q)
        IDLE: if (pop) begin
          tag_q <= head.tag;
          if (head_zero) begin
            q_q   <= '1;
            r_q   <= head.dividend;
            dbz_q <= 1'b1;
          end else begin
            // divider operands change only here, so they hold through WAIT
            dus_q <= head.usigned;
            ddd_q <= head.dividend;
            ddv_q <= head.divisor;
          end
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          wd_q <= wd_q + 1'b1;
          if (res_edge) begin
            q_q  <= bus.div_quotient;
            r_q  <= bus.div_reminder;
            wd_q <= '0;
          end else if (wd_hit) begin
            q_q  <= '0;
            r_q  <= '0;
            to_q <= 1'b1;
            wd_q <= '0;
          end
        end
        HOLD: if (bus.out_ready) begin
          dbz_q <= 1'b0;
          to_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.div_valid       = (state_q == ISSUE);
  assign bus.div_usigned     = dus_q;
  assign bus.div_dividend    = ddd_q;
  assign bus.div_divisor     = ddv_q;
  assign bus.out_valid       = (state_q == HOLD);
  assign bus.out_quotient    = q_q;
  assign bus.out_reminder    = r_q;
  assign bus.out_tag         = tag_q;
  assign bus.out_div_by_zero = dbz_q;
  assign bus.out_timeout     = to_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed cases plus randomized traffic, with a
// behavioural divider model and a queue-based reference of expected results.
module tb_div_issue_ctrl;
  localparam int P = 32, D = 4, TW = 4, TO = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.PARALLELISM(P), .TAG_W(TW)) bus ();
  div_issue_ctrl #(.PARALLELISM(P), .DEPTH(D), .TAG_W(TW), .TIMEOUT(TO))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { bit us; bit [31:0] dd; bit [31:0] dv; bit [3:0] tag; } req_t;
  req_t q_ref[$];

  // control for the divider/consumer model
  bit hang = 0;
  int lat_min = 1, lat_max = 6;
  int ordy_mode = 1;   // 0 low, 1 high, 2 random
  int pulse_req_n = 0;

  // observations
  int cyc = 0, acc_cyc, issue_cyc, edge_cyc, ovr_cyc;
  int n_issue = 0, n_res = 0;
  bit [31:0] last_q, last_r;
  bit last_dz, last_to;

  function automatic void ref_res(input req_t h, input bit hg,
                                  output bit [31:0] q, output bit [31:0] r,
                                  output bit dz, output bit to);
    dz = 0; to = 0;
    if (h.dv == 0) begin q = '1; r = h.dd; dz = 1; end
    else if (hg) begin q = 0; r = 0; to = 1; end
    else if (h.us) begin q = h.dd / h.dv; r = h.dd % h.dv; end
    else begin q = $signed(h.dd) / $signed(h.dv); r = $signed(h.dd) % $signed(h.dv); end
  endfunction

  // divider + consumer model, updates #1 after each rising edge
  initial begin
    int cnt, pulse_done_n, pstate;
    bit [31:0] a, b; bit u;
    cnt = -1; pulse_done_n = 0; pstate = 0;
    bus.div_res_ready = 0; bus.div_quotient = 0; bus.div_reminder = 0; bus.out_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (ordy_mode)
        0: bus.out_ready = 0;
        1: bus.out_ready = 1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_n) begin
        bus.div_res_ready = 0; cnt = -1; pstate = 0;
      end else if (bus.div_valid) begin
        bus.div_res_ready = 0;
        u = bus.div_usigned; a = bus.div_dividend; b = bus.div_divisor;
        bus.div_quotient = $urandom; bus.div_reminder = $urandom;
        cnt = hang ? -1 : $urandom_range(lat_min, lat_max);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (u) begin bus.div_quotient = a / b; bus.div_reminder = a % b; end
          else begin
            bus.div_quotient = $signed(a) / $signed(b);
            bus.div_reminder = $signed(a) % $signed(b);
          end
          bus.div_res_ready = 1; cnt = -1;
        end
      end else if (pstate == 1) begin
        bus.div_res_ready = 0; pstate = 0;
      end else if (pulse_done_n != pulse_req_n) begin
        pulse_done_n = pulse_req_n; bus.div_res_ready = 1; pstate = 1;
      end
    end
  end

  // monitor: reference bookkeeping and per-cycle checks on the falling edge
  initial begin
    bit prev_dv, prev_rr, prev_ov, inflight;
    bit [31:0] eq, er; bit edz, eto;
    prev_dv = 0; prev_rr = 0; prev_ov = 0; inflight = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        prev_dv = 0; prev_rr = 0; prev_ov = 0; inflight = 0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          q_ref.push_back('{bus.in_usigned, bus.in_dividend, bus.in_divisor, bus.in_tag});
          acc_cyc = cyc;
        end
        if (bus.div_valid) begin
          chk("dv_single", prev_dv, 0);
          issue_cyc = cyc; n_issue++; inflight = 1;
          if (q_ref.size() == 0) chk("dv_noreq", 1, 0);
          else begin
            chk("dv_us", bus.div_usigned, q_ref[0].us);
            chk("dv_dd", bus.div_dividend, q_ref[0].dd);
            chk("dv_dv", bus.div_divisor, q_ref[0].dv);
            chk("dv_nonzero", q_ref[0].dv == 0, 0);
          end
        end else if (inflight && !bus.out_valid && q_ref.size() != 0) begin
          chk("hold_us", bus.div_usigned, q_ref[0].us);
          chk("hold_dd", bus.div_dividend, q_ref[0].dd);
          chk("hold_dv", bus.div_divisor, q_ref[0].dv);
        end
        if (bus.div_res_ready && !prev_rr) edge_cyc = cyc;
        if (bus.out_valid) begin
          if (!prev_ov) ovr_cyc = cyc;
          inflight = 0;
          if (q_ref.size() == 0) chk("spurious_out", 1, 0);
          else begin
            ref_res(q_ref[0], hang, eq, er, edz, eto);
            chk("out_q", bus.out_quotient, eq);
            chk("out_r", bus.out_reminder, er);
            chk("out_tag", bus.out_tag, q_ref[0].tag);
            chk("out_dz", bus.out_div_by_zero, edz);
            chk("out_to", bus.out_timeout, eto);
            if (bus.out_ready) begin
              last_q = bus.out_quotient; last_r = bus.out_reminder;
              last_dz = bus.out_div_by_zero; last_to = bus.out_timeout;
              void'(q_ref.pop_front()); n_res++;
            end
          end
        end
        prev_dv = bus.div_valid; prev_rr = bus.div_res_ready; prev_ov = bus.out_valid;
      end
    end
  end

  task automatic set_req(input bit us, input bit [31:0] dd, input bit [31:0] dv, input bit [3:0] tag);
    bus.in_valid = 1; bus.in_usigned = us; bus.in_dividend = dd;
    bus.in_divisor = dv; bus.in_tag = tag;
  endtask

  // called #1 after a rising edge; returns #1 after the accepting edge
  task automatic send(input bit us, input bit [31:0] dd, input bit [31:0] dv, input bit [3:0] tag);
    bit ok = 0;
    set_req(us, dd, dv, tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q_ref.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("wait_done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic rst_chk(input string pfx);
    chk({pfx, "_ctl"}, {bus.in_ready, bus.div_valid, bus.div_usigned, bus.out_valid,
                        bus.out_div_by_zero, bus.out_timeout, bus.out_tag}, 0);
    chk({pfx, "_ops"}, {bus.div_dividend, bus.div_divisor}, 0);
    chk({pfx, "_res"}, {bus.out_quotient, bus.out_reminder}, 0);
  endtask

  initial begin
    int n0, r0;
    bit us; bit [31:0] dd, dv;
    bus.in_valid = 0; bus.in_usigned = 0; bus.in_dividend = 0; bus.in_divisor = 0; bus.in_tag = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst_chk("rst");
    @(posedge clk); #1; rst_n = 0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_idle", {bus.out_valid, bus.div_valid}, 0);
    @(posedge clk); #1;

    // unsigned 100 / 7
    lat_min = 5; lat_max = 5; n0 = n_issue;
    send(1, 100, 7, 3); wait_done();
    chk("t1_issue_lat", issue_cyc - acc_cyc, 2);
    chk("t1_out_lat", ovr_cyc - edge_cyc, 1);
    chk("t1_pulses", n_issue - n0, 1);
    chk("t1_q", last_q, 14); chk("t1_r", last_r, 2);
    chk("t1_flags", {last_dz, last_to}, 0);

    // signed -7 / 2
    lat_min = 3; lat_max = 9;
    send(0, 32'hFFFF_FFF9, 2, 5); wait_done();
    chk("t2_q", last_q, 32'hFFFF_FFFD); chk("t2_r", last_r, 32'hFFFF_FFFF);

    // divide by zero bypass
    n0 = n_issue;
    send(1, 32'h1234_5678, 0, 7); wait_done();
    chk("t3_pulses", n_issue - n0, 0);
    chk("t3_out_lat", ovr_cyc - acc_cyc, 2);
    chk("t3_q", last_q, 32'hFFFF_FFFF); chk("t3_r", last_r, 32'h1234_5678);
    chk("t3_dz", last_dz, 1);

    // backpressure: 1 in flight + 4 queued, 6th stalls
    ordy_mode = 0; lat_min = 2; lat_max = 4; r0 = n_res;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(i[0], 1000 + 37 * i, 3 + i, 4'(8 + i));
    set_req(0, 32'hFFFF_FF00, 32'hFFFF_FFF0, 4'd13);
    repeat (10) @(negedge clk);
    chk("bp_full", bus.in_ready, 0);
    chk("bp_stalled", q_ref.size(), 5);
    @(posedge clk); #1;
    ordy_mode = 1;
    send(0, 32'hFFFF_FF00, 32'hFFFF_FFF0, 4'd13);
    wait_done();
    chk("bp_results", n_res - r0, 6);

    // watchdog abort, then a late done pulse must be ignored
    hang = 1;
    send(1, 50, 5, 9); wait_done();
    chk("to_lat", ovr_cyc - (issue_cyc + 1), TO);
    chk("to_flag", last_to, 1);
    chk("to_qr", {last_q, last_r}, 0);
    hang = 0; r0 = n_res;
    pulse_req_n++;
    repeat (10) @(negedge clk);
    chk("late_edge_ignored", n_res - r0, 0);
    chk("late_edge_idle", bus.out_valid, 0);
    @(posedge clk); #1;

    // reset mid-WAIT with two queued
    lat_min = 60; lat_max = 60;
    send(1, 77, 7, 1); send(1, 88, 8, 2); send(1, 99, 9, 3);
    repeat (8) @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk); rst_chk("mid_rst");
    q_ref.delete();
    @(posedge clk); #1; rst_n = 0;
    n0 = n_issue;
    @(negedge clk);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    chk("mid_rst_fifo_empty", {bus.out_valid, 32'(n_issue - n0)}, 0);
    @(posedge clk); #1;
    lat_min = 4; lat_max = 4;
    send(1, 9, 3, 2); wait_done();
    chk("post_rst_q", last_q, 3); chk("post_rst_r", last_r, 0);

    // randomized traffic with random backpressure
    ordy_mode = 2; lat_min = 1; lat_max = 8;
    for (int i = 0; i < 40; i++) begin
      us = 1'($urandom_range(0, 1));
      dd = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 200));
      case ($urandom_range(0, 3))
        0: dv = 0;
        1: dv = 32'($urandom_range(1, 15));
        2: dv = $urandom;
        default: dv = 32'hFFFF_FFFF;
      endcase
      if (!us && dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) dv = 1;
      send(us, dd, dv, 4'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_done();
    chk("final_queue_empty", q_ref.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
